npc_ifu: RTL and testbench
==========================

// Module: npc_ifu
// PURPOSE
// - Instruction-fetch unit for the multicycle MIPS core: holds PC and instruction register (IR), and computes next PC.
// - Sits upstream of the controller: drives op/funct via IR[31:26]/IR[5:0] and consumes the controller's PCWE/npc_sel/beqout-resolved selection.
// - Also drives the instruction-memory address and the jal link value (PC+4) for the register-write mux.
// PARAMETERS
// - RESET_PC  32'h0000_3000  address of first instruction fetched after reset
// PORTS
// - clk        in   1   system clock, rising-edge
// - rst        in   1   asynchronous, active-high reset
// - PCWE       in   1   PC/IR write enable from controller (high in IF state)
// - npc_sel    in   3   000 seq, 001 jump (j/jal), 011 taken branch, 100 jr; others = seq
// - rs_data    in   32  GPR[rs], jr target
// - imem_rdata in   32  instruction word at imem_addr (combinational read)
// - imem_addr  out  32  fetch address = next PC (combinational)
// - pc         out  32  address of instruction currently in IR
// - instr      out  32  IR contents
// - pc_link    out  32  pc + 4 (jal link value)
// - addr_err   out  1   misaligned target trap (NPC_ALIGN_CHECK_EN only; else tied 0)
// BEHAVIOUR
// - Interface: one clock; reset is asynchronous and active-high (clk, rst).
// - FSM states: BOOT, RUN, HALT (HALT only with NPC_ALIGN_CHECK_EN).
// - Reset (async, any cycle incl. mid-fetch): state=BOOT, pc=RESET_PC, instr=32'h0, addr_err=0.
// - Next-PC (npc), from current pc/instr, all arithmetic mod 2^32, no overflow flag:
//   seq: pc+4; jump: {pc_link[31:28], instr[25:0], 2'b00};
//   branch: pc_link + (sign-extended instr[15:0] << 2); jr: rs_data.
// - imem_addr = RESET_PC in BOOT, else npc.
// - BOOT: PCWE=1 at edge -> instr<=imem_rdata (word at RESET_PC), pc unchanged, state->RUN. npc_sel ignored.
// - RUN: PCWE=1 at edge -> pc<=npc, instr<=imem_rdata; latency 1 cycle, new op/funct visible next cycle.
// - PCWE=0: pc, instr, state hold; npc_sel changes have no effect.
// - npc_sel is sampled only at the PCWE edge; the controller holds it stable for that cycle.
// - Wrap-around: pc=32'hFFFF_FFFC seq -> 32'h0000_0000; branch offsets wrap likewise.
// - Reserved npc_sel codes (010,101,110,111) behave exactly as 000.
// CONFIGURATION
// - NPC_ALIGN_CHECK_EN defined: in RUN, PCWE=1 with npc[1:0]!=0 -> pc/instr NOT updated,
//   addr_err<=1, state->HALT; HALT ignores PCWE, holds all outputs until rst.
// - Undefined: no check; npc used as-is, addr_err constant 0, HALT state not built.
// STRUCTURE
// - Package npc_pkg: localparams NPC_SEQ=3'b000, NPC_J=3'b001, NPC_BR=3'b011, NPC_JR=3'b100;
//   state encoding ST_BOOT/ST_RUN/ST_HALT; RESET_PC default constant.
// - Sub-module npc_calc: purely combinational next-PC mux/adders (pc, instr, rs_data, npc_sel -> npc, pc_link).
// - Top: FSM + pc/instr/addr_err registers.
// TESTING
// - Reset then PCWE pulse: imem_addr=32'h3000 in BOOT; after edge instr=word@3000, pc=32'h3000.
// - Seq: pc=32'h3000, npc_sel=000, PCWE=1 -> pc=32'h3004, pc_link before edge=32'h3004.
// - Branch: pc=32'h3010, imm=16'hFFFE, npc_sel=011 -> pc=32'h300C; imm=16'h0003 -> 32'h3020.
// - Jump/jr: pc=32'h3000, instr[25:0]=26'h0000C10, sel=001 -> 32'h0000_3040; sel=100, rs_data=32'h3008 -> 32'h3008.
// - Hold/reset: PCWE=0 for 5 cycles with npc_sel toggling -> pc/instr unchanged; rst mid-RUN -> BOOT, pc=32'h3000 immediately.
// - With NPC_ALIGN_CHECK_EN: sel=100, rs_data=32'h3002, PCWE=1 -> addr_err=1, pc unchanged, further PCWE ignored until rst.

Source files
------------

// File: rtl/npc_pkg.sv
// Purpose: shared constants and types for the instruction-fetch unit.
//   NPC_* : next-PC select encodings driven by the controller
//   state_t : fetch FSM state (ST_HALT exists only with NPC_ALIGN_CHECK_EN)
//   RESET_PC_DEFAULT : default first fetch address after reset
package npc_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] NPC_SEQ = 3'b000;
  localparam logic [2:0] NPC_J   = 3'b001;
  localparam logic [2:0] NPC_BR  = 3'b011;
  localparam logic [2:0] NPC_JR  = 3'b100;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

`ifdef NPC_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1
  } state_t;
`endif

endpackage

// File: rtl/npc_ifu_if.sv
// Purpose: controller <-> fetch-unit bundle, including the instruction-memory
// read port.
//   master : controller/memory side (drives PCWE, npc_sel, rs_data, imem_rdata)
//   slave  : fetch unit (drives imem_addr, pc, instr, pc_link, addr_err)
interface npc_ifu_if;
  import npc_pkg::*;

  logic            PCWE;
  logic [2:0]      npc_sel;
  logic [XLEN-1:0] rs_data;
  logic [XLEN-1:0] imem_rdata;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] pc_link;
  logic            addr_err;

  modport master (
    output PCWE, npc_sel, rs_data, imem_rdata,
    input  imem_addr, pc, instr, pc_link, addr_err
  );

  modport slave (
    input  PCWE, npc_sel, rs_data, imem_rdata,
    output imem_addr, pc, instr, pc_link, addr_err
  );

endinterface

// File: rtl/npc_calc.sv
// Purpose: combinational next-PC generation (all arithmetic wraps mod 2^32).
//   pc        in  current PC
//   instr_idx in  IR[25:0] (jump index; low 16 bits are the branch immediate)
//   rs_data   in  jr target
//   npc_sel   in  select; unlisted codes fall back to sequential
//   npc       out next PC
//   pc_link   out pc + 4
module npc_calc
  import npc_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [25:0]     instr_idx,
  input  logic [XLEN-1:0] rs_data,
  input  logic [2:0]      npc_sel,
  output logic [XLEN-1:0] npc,
  output logic [XLEN-1:0] pc_link
);

  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] j_tgt;

  assign pc_link = pc + XLEN'(4);

  // Word offset, sign-extended from the 16-bit immediate.
  assign br_off = {{14{instr_idx[15]}}, instr_idx[15:0], 2'b00};
  assign br_tgt = pc_link + br_off;
  assign j_tgt  = {pc_link[31:28], instr_idx, 2'b00};

  always_comb begin
    npc = pc_link;
    case (npc_sel)
      NPC_SEQ: npc = pc_link;
      NPC_J:   npc = j_tgt;
      NPC_BR:  npc = br_tgt;
      NPC_JR:  npc = rs_data;
      default: npc = pc_link;
    endcase
  end

endmodule

// File: rtl/npc_ifu.sv
// Purpose: instruction-fetch unit for the multicycle MIPS core. Holds PC and IR,
// drives the fetch address and the jal link value.
// Build option: NPC_ALIGN_CHECK_EN enables the misaligned-target trap (HALT).
//   clk, rst          clock, asynchronous active-high reset
//   bus.PCWE          PC/IR write enable (IF state)
//   bus.npc_sel       next-PC select, sampled on the PCWE edge
//   bus.rs_data       jr target
//   bus.imem_rdata    instruction word at imem_addr
//   bus.imem_addr     fetch address (combinational)
//   bus.pc/instr      current PC and IR
//   bus.pc_link       pc + 4
//   bus.addr_err      misaligned-target trap flag (0 when check not built)
module npc_ifu
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  npc_ifu_if.slave   bus
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] pc_link;
`ifdef NPC_ALIGN_CHECK_EN
  logic            err_q, err_d;
`endif

  npc_calc u_calc (
    .pc        (pc_q),
    .instr_idx (instr_q[25:0]),
    .rs_data   (bus.rs_data),
    .npc_sel   (bus.npc_sel),
    .npc       (npc),
    .pc_link   (pc_link)
  );

  // Next-state / register update logic.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
`ifdef NPC_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      // First fetch: pc already equals RESET_PC, only IR is loaded.
      ST_BOOT: begin
        if (bus.PCWE) begin
          instr_d = bus.imem_rdata;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.PCWE) begin
`ifdef NPC_ALIGN_CHECK_EN
          if (npc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d    = npc;
            instr_d = bus.imem_rdata;
          end
`else
          pc_d    = npc;
          instr_d = bus.imem_rdata;
`endif
        end
      end
`ifdef NPC_ALIGN_CHECK_EN
      // Trapped: everything frozen until reset.
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
`ifdef NPC_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
`ifdef NPC_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  assign bus.imem_addr = (state_q == ST_BOOT) ? RESET_PC : npc;
  assign bus.pc        = pc_q;
  assign bus.instr     = instr_q;
  assign bus.pc_link   = pc_link;
`ifdef NPC_ALIGN_CHECK_EN
  assign bus.addr_err  = err_q;
`else
  assign bus.addr_err  = 1'b0;
`endif

endmodule

// File: tb/tb_npc_ifu.sv
// Directed bench for npc_ifu: boot fetch, seq/branch/jump/jr targets,
// reserved selects, hold, wrap-around, async reset and the alignment trap.
module tb_npc_ifu;
  import npc_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  npc_ifu_if bus_if ();

  npc_ifu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One PCWE cycle; returns at the following falling edge.
  task automatic pulse(input logic [2:0] sel, input logic [31:0] rs, input logic [31:0] rdata);
    bus_if.PCWE       = 1'b1;
    bus_if.npc_sel    = sel;
    bus_if.rs_data    = rs;
    bus_if.imem_rdata = rdata;
    @(posedge clk);
    #1;
    bus_if.PCWE = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst               = 1'b1;
    bus_if.PCWE       = 1'b0;
    bus_if.npc_sel    = 3'b000;
    bus_if.rs_data    = '0;
    bus_if.imem_rdata = '0;
    #1;
    chk("rst_pc",    bus_if.pc,        32'h0000_3000);
    chk("rst_instr", bus_if.instr,     32'h0000_0000);
    chk("rst_err",   {31'b0, bus_if.addr_err}, 32'h0);
    chk("rst_iaddr", bus_if.imem_addr, 32'h0000_3000);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("boot_iaddr", bus_if.imem_addr, 32'h0000_3000);

    // Boot fetch; npc_sel is ignored here.
    pulse(3'b011, 32'h0, 32'h1000_FFFE);
    chk("boot_instr", bus_if.instr, 32'h1000_FFFE);
    chk("boot_pc",    bus_if.pc,    32'h0000_3000);

    // Sequential.
    bus_if.npc_sel = 3'b000;
    #1;
    chk("seq_link",  bus_if.pc_link,   32'h0000_3004);
    chk("seq_iaddr", bus_if.imem_addr, 32'h0000_3004);
    pulse(3'b000, 32'h0, 32'h1000_FFFE);
    chk("seq_pc",    bus_if.pc,    32'h0000_3004);
    chk("seq_instr", bus_if.instr, 32'h1000_FFFE);

    // jr to 3010, IR holds imm=FFFE.
    pulse(3'b100, 32'h0000_3010, 32'h1000_FFFE);
    chk("jr1_pc", bus_if.pc, 32'h0000_3010);

    // Backward branch: 3014 - 8 = 300C.
    bus_if.npc_sel = 3'b011;
    #1;
    chk("brb_iaddr", bus_if.imem_addr, 32'h0000_300C);
    pulse(3'b011, 32'h0, 32'h1000_0003);
    chk("brb_pc",    bus_if.pc,    32'h0000_300C);
    chk("brb_instr", bus_if.instr, 32'h1000_0003);

    // Back to 3010 with imm=0003, forward branch: 3014 + C = 3020.
    pulse(3'b100, 32'h0000_3010, 32'h1000_0003);
    chk("jr2_pc", bus_if.pc, 32'h0000_3010);
    pulse(3'b011, 32'h0, 32'h0800_0C10);
    chk("brf_pc", bus_if.pc, 32'h0000_3020);

    // To 3000 with IR[25:0]=C10, then jump: {0, C10, 00} = 3040.
    pulse(3'b100, 32'h0000_3000, 32'h0800_0C10);
    chk("jr3_pc",    bus_if.pc,    32'h0000_3000);
    chk("jr3_instr", bus_if.instr, 32'h0800_0C10);
    pulse(3'b001, 32'h0, 32'hAAAA_5555);
    chk("j_pc",    bus_if.pc,    32'h0000_3040);
    chk("j_instr", bus_if.instr, 32'hAAAA_5555);

    // Reserved selects act as sequential.
    pulse(3'b010, 32'h1234_5678, 32'hAAAA_5555);
    chk("rsv010_pc", bus_if.pc, 32'h0000_3044);
    pulse(3'b101, 32'h1234_5678, 32'hAAAA_5555);
    chk("rsv101_pc", bus_if.pc, 32'h0000_3048);
    pulse(3'b110, 32'h1234_5678, 32'hAAAA_5555);
    chk("rsv110_pc", bus_if.pc, 32'h0000_304C);
    pulse(3'b111, 32'h1234_5678, 32'h0000_0000);
    chk("rsv111_pc", bus_if.pc, 32'h0000_3050);

    // Hold: PCWE low, select and data wiggle.
    for (int i = 0; i < 5; i++) begin
      bus_if.npc_sel    = (i % 2 == 0) ? 3'b100 : 3'b001;
      bus_if.rs_data    = 32'h0000_7000 + 32'(i * 4);
      bus_if.imem_rdata = 32'hDEAD_0000 + 32'(i);
      @(negedge clk);
    end
    chk("hold_pc",    bus_if.pc,    32'h0000_3050);
    chk("hold_instr", bus_if.instr, 32'h0000_0000);

    // Wrap-around: FFFFFFFC seq -> 0, then branch imm=FFFE: 4 - 8 = FFFFFFFC.
    pulse(3'b100, 32'hFFFF_FFFC, 32'h1000_FFFE);
    chk("wrap_jr_pc", bus_if.pc, 32'hFFFF_FFFC);
    bus_if.npc_sel = 3'b000;
    #1;
    chk("wrap_link", bus_if.pc_link, 32'h0000_0000);
    pulse(3'b000, 32'h0, 32'h1000_FFFE);
    chk("wrap_seq_pc", bus_if.pc, 32'h0000_0000);
    pulse(3'b011, 32'h0, 32'h0000_0008);
    chk("wrap_br_pc", bus_if.pc, 32'hFFFF_FFFC);
    chk("run_err",    {31'b0, bus_if.addr_err}, 32'h0);

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_pc",    bus_if.pc,        32'h0000_3000);
    chk("arst_instr", bus_if.instr,     32'h0000_0000);
    chk("arst_iaddr", bus_if.imem_addr, 32'h0000_3000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Re-boot with jr select present; pc must stay at 3000.
    pulse(3'b100, 32'h0000_5000, 32'h0000_0008);
    chk("reboot_pc",    bus_if.pc,    32'h0000_3000);
    chk("reboot_instr", bus_if.instr, 32'h0000_0008);

    // Misaligned jr target.
    pulse(3'b100, 32'h0000_3002, 32'h1111_1111);
`ifdef NPC_ALIGN_CHECK_EN
    chk("mis_err",   {31'b0, bus_if.addr_err}, 32'h1);
    chk("mis_pc",    bus_if.pc,    32'h0000_3000);
    chk("mis_instr", bus_if.instr, 32'h0000_0008);
    pulse(3'b000, 32'h0, 32'h2222_2222);
    chk("halt_pc",    bus_if.pc,    32'h0000_3000);
    chk("halt_instr", bus_if.instr, 32'h0000_0008);
    chk("halt_err",   {31'b0, bus_if.addr_err}, 32'h1);
    rst = 1'b1;
    #1;
    chk("halt_rst_err", {31'b0, bus_if.addr_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
`else
    chk("mis_err",   {31'b0, bus_if.addr_err}, 32'h0);
    chk("mis_pc",    bus_if.pc,    32'h0000_3002);
    chk("mis_instr", bus_if.instr, 32'h1111_1111);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
